mul_div_seq: RTL and testbench

//  EBOX multiply/divide step sequencer. Drives AD function, AR/ARX load/shift
//  and MQ select controls for the CTL/EDP datapath, one bit per step, for
//  36-bit signed multiply (shift-add) and non-restoring divide. Microcode

---
 rtl/mul_div_seq.sv | 181 ++++++++++++++++++
 tb/tb_mul_div_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_seq.sv
// EBOX multiply/divide step sequencer.
// Walks the CTL/EDP datapath through a 36-bit signed shift-add multiply or a
// non-restoring divide, one quotient/multiplier bit per step, and decodes the
// AD/AR/MQ controls for each step from the registered state.
module mul_div_seq #(
    parameter int unsigned STEPS = 36,
    parameter int unsigned CNT_W = 6
) (
    input  logic             eboxClk,
    input  logic             eboxReset,
    input  logic             start,
    input  logic             opDiv,
    input  logic             mulNeg,
    input  logic             abort,
    input  logic             EDP_MQ35,
    input  logic             EDP_ADsign,
    output logic [1:0]       SEQ_ADfunc,
    output logic             SEQ_ARload,
    output logic [1:0]       SEQ_ARshift,
    output logic [1:0]       SEQ_MQ_SEL,
    output logic             SEQ_MQ_Qbit,
    output logic             SEQ_busy,
    output logic             SEQ_done,
    output logic             SEQ_divOvf,
    output logic [CNT_W-1:0] SEQ_stepCount
);

    typedef enum logic [2:0] {
        StIdle,
        StMulStep,
        StMulFix,
        StDivChk,
        StDivStep,
        StDivFix,
        StDone
    } state_t;

    // AD function codes
    localparam logic [1:0] AdAr    = 2'd0;
    localparam logic [1:0] AdAdd   = 2'd1;
    localparam logic [1:0] AdSub   = 2'd2;
    // AR shift / MQ select codes share the same encoding
    localparam logic [1:0] ShNone  = 2'd0;
    localparam logic [1:0] ShRight = 2'd1;
    localparam logic [1:0] ShLeft  = 2'd2;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_prev_q, q_prev_d;
    logic             ovf_q, ovf_d;
    logic             mul_neg_q, mul_neg_d;

    // State and datapath-control registers, synchronous active-high reset
    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            q_prev_q  <= 1'b0;
            ovf_q     <= 1'b0;
            mul_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            q_prev_q  <= q_prev_d;
            ovf_q     <= ovf_d;
            mul_neg_q <= mul_neg_d;
        end
    end

    // Next-state and register-update logic; abort overrides every transition
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_prev_d  = q_prev_q;
        ovf_d     = ovf_q;
        mul_neg_d = mul_neg_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d     = LastCnt;
                    mul_neg_d = mulNeg;
                    state_d   = opDiv ? StDivChk : StMulStep;
                end
            end
            StMulStep: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntOne;
                end else begin
                    state_d = StMulFix;
                end
            end
            StMulFix: state_d = StDone;
            StDivChk: begin
                // Non-negative trial difference means the quotient cannot fit
                if (!EDP_ADsign) begin
                    ovf_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    q_prev_d = 1'b1;
                    state_d  = StDivStep;
                end
            end
            StDivStep: begin
                q_prev_d = ~EDP_ADsign;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntOne;
                end else begin
                    state_d = StDivFix;
                end
            end
            StDivFix: state_d = StDone;
            StDone: begin
                ovf_d    = 1'b0;
                q_prev_d = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d   = StIdle;
            cnt_d     = cnt_q;
            mul_neg_d = mul_neg_q;
            ovf_d     = 1'b0;
            q_prev_d  = 1'b0;
        end
    end

    // Datapath control decode from registered state plus live EDP bits
    always_comb begin
        SEQ_ADfunc  = AdAr;
        SEQ_ARload  = 1'b0;
        SEQ_ARshift = ShNone;
        SEQ_MQ_SEL  = ShNone;
        SEQ_MQ_Qbit = 1'b0;
        SEQ_busy    = (state_q != StIdle);
        SEQ_done    = 1'b0;
        SEQ_divOvf  = 1'b0;
        unique case (state_q)
            StIdle: ;
            StMulStep: begin
                SEQ_ADfunc  = EDP_MQ35 ? AdAdd : AdAr;
                SEQ_ARload  = 1'b1;
                SEQ_ARshift = ShRight;
                SEQ_MQ_SEL  = ShRight;
            end
            StMulFix: begin
                // Negative multiplier: subtract the over-counted sign weight
                if (mul_neg_q) begin
                    SEQ_ADfunc = AdSub;
                    SEQ_ARload = 1'b1;
                end
            end
            StDivChk: SEQ_ADfunc = AdSub;
            StDivStep: begin
                SEQ_ADfunc  = q_prev_q ? AdSub : AdAdd;
                SEQ_ARload  = 1'b1;
                SEQ_ARshift = ShLeft;
                SEQ_MQ_SEL  = ShLeft;
                SEQ_MQ_Qbit = ~EDP_ADsign;
            end
            StDivFix: begin
                // Negative remainder: add the divisor back once
                if (!q_prev_q) begin
                    SEQ_ADfunc = AdAdd;
                    SEQ_ARload = 1'b1;
                end
            end
            StDone: begin
                SEQ_done   = ~abort;
                SEQ_divOvf = ovf_q & ~abort;
            end
            default: ;
        endcase
    end

    assign SEQ_stepCount = cnt_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed/random bench for mul_div_seq against a cycle-by-cycle control model.
module tb_mul_div_seq;

    localparam int S = 36;

    logic       eboxClk = 1'b0;
    logic       eboxReset, start, opDiv, mulNeg, abort, EDP_MQ35, EDP_ADsign;
    logic [1:0] SEQ_ADfunc, SEQ_ARshift, SEQ_MQ_SEL;
    logic       SEQ_ARload, SEQ_MQ_Qbit, SEQ_busy, SEQ_done, SEQ_divOvf;
    logic [5:0] SEQ_stepCount;

    int errors = 0;
    int checks = 0;
    int mcnt   = 0;   // model's step count visible in the current cycle

    mul_div_seq #(.STEPS(S), .CNT_W(6)) dut (
        .eboxClk      (eboxClk),
        .eboxReset    (eboxReset),
        .start        (start),
        .opDiv        (opDiv),
        .mulNeg       (mulNeg),
        .abort        (abort),
        .EDP_MQ35     (EDP_MQ35),
        .EDP_ADsign   (EDP_ADsign),
        .SEQ_ADfunc   (SEQ_ADfunc),
        .SEQ_ARload   (SEQ_ARload),
        .SEQ_ARshift  (SEQ_ARshift),
        .SEQ_MQ_SEL   (SEQ_MQ_SEL),
        .SEQ_MQ_Qbit  (SEQ_MQ_Qbit),
        .SEQ_busy     (SEQ_busy),
        .SEQ_done     (SEQ_done),
        .SEQ_divOvf   (SEQ_divOvf),
        .SEQ_stepCount(SEQ_stepCount)
    );

    always #5 eboxClk = ~eboxClk;

    logic [10:0] obs_v;
    assign obs_v = {SEQ_ADfunc, SEQ_ARload, SEQ_ARshift, SEQ_MQ_SEL, SEQ_MQ_Qbit,
                    SEQ_busy, SEQ_done, SEQ_divOvf};

    function automatic logic [10:0] ov(int adf, bit ld, int sh, int mq, bit qb,
                                       bit bsy, bit dn, bit of);
        logic [1:0] a, s, m;
        a = adf[1:0];
        s = sh[1:0];
        m = mq[1:0];
        return {a, ld, s, m, qb, bsy, dn, of};
    endfunction

    localparam logic [10:0] Quiet = 11'd0;
    localparam logic [10:0] BusyOnly = 11'b000_0000_0100;

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are set by the caller just after a rising edge; sample mid-cycle.
    task automatic cyc(string tag, logic [10:0] ev);
        @(negedge eboxClk);
        chk({tag, "/ctl"}, 16'(obs_v), 16'(ev));
        chk({tag, "/cnt"}, 16'(SEQ_stepCount), 16'(mcnt));
        @(posedge eboxClk);
        #1;
    endtask

    task automatic run_mul(input logic neg, input logic [S-1:0] bits, input logic abort_done);
        start = 1; opDiv = 0; mulNeg = neg;
        cyc("mul_start", Quiet);
        start = 0; mulNeg = 0; mcnt = S - 1;
        for (int k = 0; k < S; k++) begin
            EDP_MQ35 = bits[k];
            cyc("mul_step", ov(bits[k] ? 1 : 0, 1, 1, 1, 0, 1, 0, 0));
            if (mcnt > 0) mcnt--;
        end
        EDP_MQ35 = 1'($urandom);
        cyc("mul_fix", neg ? ov(2, 1, 0, 0, 0, 1, 0, 0) : BusyOnly);
        abort = abort_done;
        cyc("mul_done", ov(0, 0, 0, 0, 0, 1, !abort_done, 0));
        abort = 0; EDP_MQ35 = 0;
        cyc("mul_idle", Quiet);
    endtask

    task automatic run_div(input logic chkbit, input logic [S-1:0] ad);
        logic q;
        start = 1; opDiv = 1; mulNeg = 1'($urandom);
        cyc("div_start", Quiet);
        start = 0; opDiv = 0; mulNeg = 0; mcnt = S - 1;
        EDP_ADsign = chkbit;
        cyc("div_chk", ov(2, 0, 0, 0, 0, 1, 0, 0));
        if (!chkbit) begin
            EDP_ADsign = 1'($urandom);
            cyc("div_ovf_done", ov(0, 0, 0, 0, 0, 1, 1, 1));
        end else begin
            q = 1'b1;
            for (int k = 0; k < S; k++) begin
                EDP_ADsign = ad[k];
                cyc("div_step", ov(q ? 2 : 1, 1, 2, 2, !ad[k], 1, 0, 0));
                q = !ad[k];
                if (mcnt > 0) mcnt--;
            end
            EDP_ADsign = 1'($urandom);
            cyc("div_fix", q ? BusyOnly : ov(1, 1, 0, 0, 0, 1, 0, 0));
            EDP_ADsign = 1'($urandom);
            cyc("div_done", ov(0, 0, 0, 0, 0, 1, 1, 0));
        end
        EDP_ADsign = 0;
        cyc("div_idle", Quiet);
    endtask

    function automatic logic [S-1:0] rnd_bits();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[S-1:0];
    endfunction

    initial begin
        logic [S-1:0] alt;
        for (int k = 0; k < S; k++) alt[k] = (k % 2 == 0);

        eboxReset = 1; start = 0; opDiv = 0; mulNeg = 0; abort = 0;
        EDP_MQ35 = 0; EDP_ADsign = 0;
        @(posedge eboxClk);
        #1;
        cyc("reset", Quiet);
        eboxReset = 0;

        // abort beats start in IDLE
        start = 1; abort = 1;
        cyc("idle_abort_start", Quiet);
        start = 0; abort = 0;
        cyc("idle_abort_after", Quiet);

        run_mul(0, alt, 0);
        run_mul(1, rnd_bits(), 0);
        run_mul(1'($urandom), rnd_bits(), 1);   // abort in DONE hides done
        run_div(0, rnd_bits());
        run_div(1, ~alt);                       // steps 0,1,0,..: final qPrev=0
        run_div(1, alt);                        // final qPrev=1: no restore
        for (int i = 0; i < 3; i++) run_div(1, rnd_bits());
        for (int i = 0; i < 2; i++) run_mul(1'($urandom), rnd_bits(), 0);

        // synchronous reset in the middle of a multiply
        start = 1; opDiv = 0; mulNeg = 1;
        cyc("rst_start", Quiet);
        start = 0; mulNeg = 0; mcnt = S - 1;
        for (int k = 0; k < 16; k++) begin
            EDP_MQ35 = 1'($urandom);
            if (mcnt == 20) eboxReset = 1;
            cyc("rst_step", ov(EDP_MQ35 ? 1 : 0, 1, 1, 1, 0, 1, 0, 0));
            if (mcnt > 0) mcnt--;
        end
        eboxReset = 0; EDP_MQ35 = 0; mcnt = 0;
        for (int i = 0; i < 3; i++) cyc("rst_idle", Quiet);

        // start ignored while busy, abort at count 5
        start = 1; opDiv = 0; mulNeg = 0;
        cyc("abt_start", Quiet);
        start = 0; mcnt = S - 1;
        while (mcnt >= 5) begin
            EDP_MQ35 = 1'($urandom);
            start = (mcnt == 30);
            opDiv = start;
            abort = (mcnt == 5);
            cyc("abt_step", ov(EDP_MQ35 ? 1 : 0, 1, 1, 1, 0, 1, 0, 0));
            if (abort) break;
            mcnt--;
        end
        abort = 0; start = 0; opDiv = 0; EDP_MQ35 = 0;
        for (int i = 0; i < 3; i++) cyc("abt_idle", Quiet);
        run_div(1, rnd_bits());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
